// File: rtl/snitch_ssr_cfg_arbiter.sv
// Round-robin arbiter sharing SSR configuration ports between requesters.
// Supports lockable grants, 1-cycle read responses and broadcast writes.
module snitch_ssr_cfg_arbiter #(
  parameter int unsigned NumReq      = 2,
  parameter int unsigned NumSsr      = 3,
  parameter int unsigned SsrIdxWidth = 5
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NumReq-1:0]             req_valid_i,
  output logic [NumReq-1:0]             req_ready_o,
  input  logic [NumReq*SsrIdxWidth-1:0] req_ssr_i,
  input  logic [NumReq*5-1:0]           req_word_i,
  input  logic [NumReq-1:0]             req_write_i,
  input  logic [NumReq*32-1:0]          req_wdata_i,
  input  logic [NumReq-1:0]             req_lock_i,
  output logic [NumReq-1:0]             rsp_valid_o,
  output logic [NumReq*32-1:0]          rsp_rdata_o,
  output logic [NumSsr*5-1:0]           ssr_cfg_word_o,
  output logic [NumSsr-1:0]             ssr_cfg_write_o,
  output logic [NumSsr*32-1:0]          ssr_cfg_wdata_o,
  input  logic [NumSsr*32-1:0]          ssr_cfg_rdata_i,
  input  logic [NumSsr-1:0]             ssr_cfg_wready_i
);

  localparam int unsigned ReqIdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam logic [SsrIdxWidth-1:0] BcastIdx = '1;

  typedef logic [ReqIdxW-1:0] req_idx_t;
  typedef enum logic {Idle, Bcast} state_e;

  logic [NumReq-1:0][SsrIdxWidth-1:0] ssr_v;
  logic [NumReq-1:0][4:0]             word_v;
  logic [NumReq-1:0][31:0]            wdata_v;
  logic [NumSsr-1:0][31:0]            rdata_v;

  assign ssr_v   = req_ssr_i;
  assign word_v  = req_word_i;
  assign wdata_v = req_wdata_i;
  assign rdata_v = ssr_cfg_rdata_i;

  state_e            state_q, state_d;
  req_idx_t          ptr_q, ptr_d;
  req_idx_t          owner_q, owner_d;
  req_idx_t          held_idx_q, held_idx_d;
  logic              locked_q, locked_d;
  logic              held_q, held_d;
  logic [NumSsr-1:0] done_q, done_d;
  logic [NumReq-1:0] rsp_valid_q, rsp_valid_d;
  logic [NumReq-1:0][31:0] rsp_rdata_q, rsp_rdata_d;

  logic                   win_vld;
  req_idx_t               win;
  req_idx_t               cand;
  logic [SsrIdxWidth-1:0] w_ssr;
  logic                   w_write;
  logic                   is_bcast;
  logic                   in_range;
  logic                   complete;
  logic [31:0]            rd_data;
  logic [NumSsr-1:0]      bc_drv;
  logic [NumSsr-1:0]      bc_done;
  logic [NumSsr-1:0][4:0]  cfg_word;
  logic [NumSsr-1:0]       cfg_write;
  logic [NumSsr-1:0][31:0] cfg_wdata;

  // A stalled grant is pinned until it completes.
  always_comb begin
    win_vld = 1'b0;
    win     = '0;
    cand    = '0;
    if (held_q) begin
      win_vld = req_valid_i[held_idx_q];
      win     = held_idx_q;
    end else if (locked_q) begin
      win_vld = req_valid_i[owner_q];
      win     = owner_q;
    end else begin
      for (int unsigned k = 0; k < NumReq; k++) begin
        cand = req_idx_t'((int'(ptr_q) + k) % NumReq);
        if (!win_vld && req_valid_i[cand]) begin
          win_vld = 1'b1;
          win     = cand;
        end
      end
    end
  end

  assign w_ssr    = ssr_v[win];
  assign w_write  = req_write_i[win];
  assign is_bcast = (w_ssr == BcastIdx);
  assign in_range = (w_ssr < SsrIdxWidth'(NumSsr));
  assign bc_drv   = (state_q == Bcast) ? ~done_q : '1;
  assign bc_done  = done_q | ssr_cfg_wready_i;

  always_comb begin
    state_d   = state_q;
    done_d    = done_q;
    complete  = 1'b0;
    rd_data   = '0;
    cfg_word  = '0;
    cfg_write = '0;
    cfg_wdata = '0;
    if (win_vld) begin
      unique case (1'b1)
        is_bcast && w_write: begin
          for (int s = 0; s < NumSsr; s++) begin
            if (bc_drv[s]) begin
              cfg_word[s]  = word_v[win];
              cfg_write[s] = 1'b1;
              cfg_wdata[s] = wdata_v[win];
            end
          end
          if (&bc_done) begin
            complete = 1'b1;
            done_d   = '0;
            state_d  = Idle;
          end else begin
            done_d  = bc_done;
            state_d = Bcast;
          end
        end
        in_range: begin
          for (int s = 0; s < NumSsr; s++) begin
            if (w_ssr == SsrIdxWidth'(s)) begin
              cfg_word[s] = word_v[win];
              if (w_write) begin
                cfg_write[s] = 1'b1;
                cfg_wdata[s] = wdata_v[win];
                complete     = ssr_cfg_wready_i[s];
              end else begin
                complete = 1'b1;
                rd_data  = rdata_v[s];
              end
            end
          end
        end
        default: complete = 1'b1;
      endcase
    end
  end

  always_comb begin
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    locked_d    = locked_q;
    held_d      = win_vld && !complete;
    held_idx_d  = win;
    rsp_valid_d = '0;
    rsp_rdata_d = '0;
    if (complete) begin
      ptr_d    = (win == req_idx_t'(NumReq - 1)) ? '0 : win + 1'b1;
      owner_d  = win;
      locked_d = req_lock_i[win];
      if (!w_write) begin
        rsp_valid_d[win] = 1'b1;
        rsp_rdata_d[win] = rd_data;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= Idle;
      done_q      <= '0;
      ptr_q       <= '0;
      owner_q     <= '0;
      locked_q    <= 1'b0;
      held_q      <= 1'b0;
      held_idx_q  <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      done_q      <= done_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      locked_q    <= locked_d;
      held_q      <= held_d;
      held_idx_q  <= held_idx_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  always_comb begin
    for (int r = 0; r < NumReq; r++) begin
      req_ready_o[r] = rst_ni && complete && (win == req_idx_t'(r));
    end
  end

  assign rsp_valid_o     = rsp_valid_q;
  assign rsp_rdata_o     = rsp_rdata_q;
  assign ssr_cfg_word_o  = rst_ni ? cfg_word  : '0;
  assign ssr_cfg_write_o = rst_ni ? cfg_write : '0;
  assign ssr_cfg_wdata_o = rst_ni ? cfg_wdata : '0;

endmodule

// File: tb/tb_snitch_ssr_cfg_arbiter.sv
// Directed bench for snitch_ssr_cfg_arbiter.
// Inputs change after posedge; outputs are checked on negedge.
module tb_snitch_ssr_cfg_arbiter;
  localparam int NR = 2;
  localparam int NS = 3;
  localparam int IW = 5;

  logic clk = 1'b0;
  logic rst_n;
  logic [NR-1:0]    req_valid, req_ready, req_write, req_lock, rsp_valid;
  logic [NR*IW-1:0] req_ssr;
  logic [NR*5-1:0]  req_word;
  logic [NR*32-1:0] req_wdata, rsp_rdata;
  logic [NS*5-1:0]  cfg_word;
  logic [NS-1:0]    cfg_write, cfg_wready;
  logic [NS*32-1:0] cfg_wdata, cfg_rdata;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  snitch_ssr_cfg_arbiter #(
    .NumReq(NR), .NumSsr(NS), .SsrIdxWidth(IW)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .req_valid_i(req_valid),
    .req_ready_o(req_ready),
    .req_ssr_i(req_ssr),
    .req_word_i(req_word),
    .req_write_i(req_write),
    .req_wdata_i(req_wdata),
    .req_lock_i(req_lock),
    .rsp_valid_o(rsp_valid),
    .rsp_rdata_o(rsp_rdata),
    .ssr_cfg_word_o(cfg_word),
    .ssr_cfg_write_o(cfg_write),
    .ssr_cfg_wdata_o(cfg_wdata),
    .ssr_cfg_rdata_i(cfg_rdata),
    .ssr_cfg_wready_i(cfg_wready)
  );

  task automatic chk(input string tag, input logic [95:0] got,
                     input logic [95:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drv(input bit r, input logic v, input logic [4:0] s,
                     input logic [4:0] w, input logic wr,
                     input logic [31:0] d, input logic lk);
    req_valid[r] = v;
    req_ssr[int'(r)*IW +: IW] = s;
    req_word[int'(r)*5 +: 5] = w;
    req_write[r] = wr;
    req_wdata[int'(r)*32 +: 32] = d;
    req_lock[r] = lk;
  endtask

  task automatic idle();
    req_valid = '0;
    req_ssr = '0;
    req_word = '0;
    req_write = '0;
    req_wdata = '0;
    req_lock = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic pulse_rst();
    rst_n = 1'b0;
    idle();
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    cfg_wready = '1;
    cfg_rdata = {32'h2222_2222, 32'hCAFE_0001, 32'h1111_1111};
    settle();
    chk("rst_ready", req_ready, 0);
    chk("rst_rspv", rsp_valid, 0);
    chk("rst_rspd", rsp_rdata, 0);
    chk("rst_word", cfg_word, 0);
    chk("rst_write", cfg_write, 0);
    chk("rst_wdata", cfg_wdata, 0);
    rst_n = 1'b1;
    tick();

    // unicast read
    drv(0, 1, 5'd1, 5'd3, 0, 0, 0);
    settle();
    chk("rd_ready", req_ready, 2'b01);
    chk("rd_word", cfg_word, 15'h0060);
    chk("rd_write", cfg_write, 0);
    chk("rd_wdata", cfg_wdata, 0);
    chk("rd_early", rsp_valid, 0);
    tick();
    idle();
    settle();
    chk("rd_rspv", rsp_valid, 2'b01);
    chk("rd_rspd", rsp_rdata, 64'hCAFE_0001);
    tick();
    settle();
    chk("rd_pulse", rsp_valid, 0);
    tick();

    // back-to-back reads, response overlaps next acceptance
    drv(0, 1, 5'd0, 5'd1, 0, 0, 0);
    settle();
    chk("b2b_rdy0", req_ready, 2'b01);
    tick();
    drv(0, 1, 5'd2, 5'd4, 0, 0, 0);
    settle();
    chk("b2b_rdy1", req_ready, 2'b01);
    chk("b2b_word", cfg_word, 15'h1000);
    chk("b2b_rspv0", rsp_valid, 2'b01);
    chk("b2b_rspd0", rsp_rdata, 64'h1111_1111);
    tick();
    idle();
    settle();
    chk("b2b_rspv1", rsp_valid, 2'b01);
    chk("b2b_rspd1", rsp_rdata, 64'h2222_2222);
    tick();

    // alternating writes from a fresh pointer
    pulse_rst();
    tick();
    drv(0, 1, 5'd0, 5'd1, 1, 32'hA0, 0);
    drv(1, 1, 5'd0, 5'd1, 1, 32'hB1, 0);
    for (int i = 0; i < 4; i++) begin
      settle();
      chk($sformatf("rr_rdy%0d", i), req_ready,
          (i % 2 == 0) ? 2'b01 : 2'b10);
      chk($sformatf("rr_wd%0d", i), cfg_wdata,
          (i % 2 == 0) ? 96'hA0 : 96'hB1);
      chk($sformatf("rr_wr%0d", i), cfg_write, 3'b001);
      tick();
    end
    drv(1, 0, 0, 0, 0, 0, 0);
    settle();
    chk("rr_solo", req_ready, 2'b01);
    tick();

    // locked burst from req1 while req0 waits
    for (int i = 0; i < 4; i++) begin
      drv(1, 1, 5'd2, 5'd5, 1, 32'hC0 + i, (i < 3));
      settle();
      chk($sformatf("lk_rdy%0d", i), req_ready, 2'b10);
      chk($sformatf("lk_wd%0d", i), cfg_wdata,
          {32'hC0 + i, 64'h0});
      tick();
    end
    drv(1, 0, 0, 0, 0, 0, 0);
    settle();
    chk("lk_rel", req_ready, 2'b01);
    tick();
    idle();

    // broadcast write with staggered wready
    cfg_wready = 3'b001;
    drv(0, 1, 5'h1F, 5'd2, 1, 32'h10, 0);
    settle();
    chk("bc_wr0", cfg_write, 3'b111);
    chk("bc_rdy0", req_ready, 0);
    tick();
    cfg_wready = 3'b100;
    settle();
    chk("bc_wr1", cfg_write, 3'b110);
    chk("bc_rdy1", req_ready, 0);
    tick();
    cfg_wready = 3'b000;
    settle();
    chk("bc_wr2", cfg_write, 3'b010);
    chk("bc_rdy2", req_ready, 0);
    tick();
    cfg_wready = 3'b010;
    settle();
    chk("bc_wr3", cfg_write, 3'b010);
    chk("bc_rdy3", req_ready, 2'b01);
    chk("bc_word3", cfg_word, 15'h0040);
    chk("bc_wd3", cfg_wdata, {32'h0, 32'h10, 32'h0});
    tick();
    idle();
    cfg_wready = 3'b111;
    settle();
    chk("bc_wr4", cfg_write, 0);
    chk("bc_rdy4", req_ready, 0);
    tick();

    // out-of-range and broadcast reads
    drv(0, 1, 5'd7, 5'd3, 0, 0, 0);
    settle();
    chk("oor_rdy", req_ready, 2'b01);
    chk("oor_word", cfg_word, 0);
    chk("oor_wr", cfg_write, 0);
    tick();
    idle();
    drv(1, 1, 5'h1F, 5'd3, 0, 0, 0);
    settle();
    chk("bcr_rdy", req_ready, 2'b10);
    chk("bcr_word", cfg_word, 0);
    chk("oor_rspv", rsp_valid, 2'b01);
    chk("oor_rspd", rsp_rdata, 0);
    tick();
    idle();
    settle();
    chk("bcr_rspv", rsp_valid, 2'b10);
    chk("bcr_rspd", rsp_rdata, 0);
    tick();

    // reset in the middle of a broadcast
    cfg_wready = 3'b001;
    drv(0, 1, 5'h1F, 5'd2, 1, 32'h55, 0);
    settle();
    chk("mr_wr0", cfg_write, 3'b111);
    tick();
    rst_n = 1'b0;
    #1;
    chk("mr_rdy", req_ready, 0);
    chk("mr_wr", cfg_write, 0);
    chk("mr_word", cfg_word, 0);
    chk("mr_wd", cfg_wdata, 0);
    chk("mr_rspv", rsp_valid, 0);
    tick();
    idle();
    rst_n = 1'b1;
    cfg_wready = 3'b000;
    drv(1, 1, 5'd1, 5'd6, 1, 32'h77, 0);
    settle();
    chk("pw_stall", req_ready, 0);
    chk("pw_wr", cfg_write, 3'b010);
    chk("pw_wd", cfg_wdata, {32'h0, 32'h77, 32'h0});
    tick();
    cfg_wready = 3'b010;
    settle();
    chk("pw_rdy", req_ready, 2'b10);
    tick();
    idle();
    cfg_wready = 3'b111;
    drv(0, 1, 5'h1F, 5'd2, 1, 32'h99, 0);
    settle();
    chk("pb_wr", cfg_write, 3'b111);
    chk("pb_rdy", req_ready, 2'b01);
    tick();
    idle();
    settle();
    chk("pb_idle", cfg_write, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule

// File: doc/snitch_ssr_cfg_arbiter.md
Name: snitch_ssr_cfg_arbiter

Overview:
Shares the configuration register ports of NumSsr stream semantic registers (SSRs) between NumReq requesters, for example the core's SSR CSR path and a configuration prefetch/sequencer unit. It arbitrates round-robin with an optional lock, so that multi-write setup bursts are not interleaved. It returns read data with a fixed 1-cycle latency. It supports broadcast writes to all SSRs, tracking per-SSR completion. It sits between the requesters and the SSR cfg_word/cfg_write/cfg_wdata/cfg_rdata/cfg_wready ports.

Parameters:
NumReq, 2, number of requesters (>=1)
NumSsr, 3, number of SSRs served (1..2^SsrIdxWidth-1)
SsrIdxWidth, 5, width of SSR select field; the all-ones value means broadcast

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
req_valid_i  in  NumReq  request valid per requester
req_ready_o  out  NumReq  request accepted (handshake completes this cycle)
req_ssr_i  in  NumReq*SsrIdxWidth  target SSR index; all-ones = broadcast
req_word_i  in  NumReq*5  cfg register word
req_write_i  in  NumReq  1 = write, 0 = read
req_wdata_i  in  NumReq*32  write data
req_lock_i  in  NumReq  keep grant after this transaction
rsp_valid_o  out  NumReq  read response valid (1-cycle pulse, no backpressure)
rsp_rdata_o  out  NumReq*32  read data
ssr_cfg_word_o  out  NumSsr*5  to SSR cfg_word_i
ssr_cfg_write_o  out  NumSsr  to SSR cfg_write_i
ssr_cfg_wdata_o  out  NumSsr*32  to SSR cfg_wdata_i
ssr_cfg_rdata_i  in  NumSsr*32  from SSR cfg_rdata_o (combinational)
ssr_cfg_wready_i  in  NumSsr  from SSR cfg_wready_o

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_ni is asynchronous, active-low.
- Reset values:
  - req_ready_o=0, rsp_valid_o=0, rsp_rdata_o=0.
  - All ssr_cfg_* outputs 0.
  - RR pointer 0, unlocked, state IDLE, broadcast done-mask 0.
- Arbitration: round-robin starting at the pointer, among requesters with valid=1.
  - If locked, only the lock owner is eligible; others stall with ready=0.
- Requester rule: once valid rises, the request must hold stable until ready.
  - The arbiter holds the grant on a stalled request; no re-arbitration until it completes.
- Completion of the granted request (ready=1 for exactly that cycle):
  - Pointer becomes winner+1 mod NumReq.
  - Lock owner := winner if req_lock_i=1, else lock released.
- SSR output drive:
  - Only the targeted SSR(s) see a non-zero word/write/wdata.
  - Untargeted SSRs see word=0, write=0, wdata=0.
- Unicast read (index < NumSsr):
  - Drive word to the target and complete the same cycle.
  - Register the target's rdata; rsp_valid_o[winner]=1 with that rdata on the next cycle, otherwise 0.
- Unicast write:
  - Drive word, write=1 and wdata to the target.
  - Complete in the cycle the target's wready=1; wait otherwise.
  - Writes produce no response.
- Out-of-range index (>= NumSsr, not broadcast): complete immediately, drive nothing.
  - A read in this case responds next cycle with rdata=0.
- Broadcast read: same as out-of-range (rdata=0).
- Broadcast write, state machine IDLE -> BCAST -> IDLE:
  - In IDLE with a granted broadcast write, drive write to all SSRs.
  - done_mask_next = done_mask | wready. If all NumSsr bits are set, complete this cycle and stay IDLE (single-cycle case). Otherwise go to BCAST.
  - In BCAST, drive write only to SSRs whose done bit is 0; accumulate wready. When all bits are set, complete, clear the mask and return to IDLE.
  - Each SSR is written exactly once per broadcast.
- Throughput: one transaction per cycle when targets are ready, with no bubble between back-to-back requests.
- Simultaneous events:
  - A read response pulse for the previous read coexists with acceptance of a new request, including from the same requester.
  - A lock request from a non-owner is ignored until it wins.
- Reset mid-broadcast: the arbiter returns to IDLE with the mask cleared. SSRs already written keep their values.

Test Plan:
- Req0 reads SSR1 word 3, ssr_cfg_rdata_i[1]=0xCAFE0001 -> req_ready_o[0]=1 same cycle; next cycle rsp_valid_o[0]=1, rsp_rdata_o[0]=0xCAFE0001; SSR0/SSR2 outputs all 0.
- Req0 and req1 continuously issue writes to SSR0, wready=1 -> grants alternate 0,1,0,1; one write per cycle.
- Req1 issues 4 writes with lock=1,1,1,0 while req0 is valid throughout -> all 4 req1 writes complete back-to-back; req0 is granted on the 5th cycle.
- Broadcast write of 0x10 to word 2; SSR wready arrive SSR0@c0, SSR2@c1, SSR1@c3 -> each SSR sees write=1 until its own wready, then 0; req_ready_o pulses at c3; no re-write of SSR0.
- Read to index 7 with NumSsr=3, and broadcast read -> immediate ready; next-cycle rsp with rdata=0; no ssr_cfg_* activity.
- Assert rst_ni=0 at c1 of the broadcast above, then release and issue a unicast write to SSR1 -> during reset all outputs are 0; after release the write completes normally with no leftover mask bits.
